ai_shot_sequencer: RTL and testbench

Upstream driver for the `ai` targeting core.
- Keeps the 10x10 fired-cell bitmap and the alive-ship mask for the current game, from shot results reported by the game controller.
- On each shot request, acts as the Avalon-MM master into `ai`: loads the board, starts the density computation, reads back the chosen cell and presents it to the game controller.
- Replaces the hand-driven register sequence with a self-contained sequencer.

---
 rtl/ai_shot_sequencer_if.sv | 27 ++
 rtl/ai_shot_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_ai_shot_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ai_shot_sequencer_if.sv
// rtl/ai_shot_sequencer_if.sv - Avalon-MM link between the shot sequencer and the ai targeting core
interface ai_shot_sequencer_if;
    logic [2:0]  ai_addr;
    logic        ai_write_en;
    logic        ai_read_en;
    logic [63:0] ai_data_in;
    logic        ai_wait_request;
    logic [63:0] ai_data_out;

    modport master (
        output ai_addr,
        output ai_write_en,
        output ai_read_en,
        output ai_data_in,
        input  ai_wait_request,
        input  ai_data_out
    );

    modport slave (
        input  ai_addr,
        input  ai_write_en,
        input  ai_read_en,
        input  ai_data_in,
        output ai_wait_request,
        output ai_data_out
    );
endinterface

// File: rtl/ai_shot_sequencer.sv
// rtl/ai_shot_sequencer.sv - board/ship tracker that drives the ai core over Avalon-MM and presents its chosen shot
module ai_shot_sequencer #(
    parameter int CELLS      = 100,
    parameter int WORD_CELLS = 25
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   new_game,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [6:0]             res_index,
    input  logic                   res_sunk,
    input  logic [2:0]             res_sunk_id,
    input  logic                   shot_req,
    output logic                   shot_valid,
    input  logic                   shot_ready,
    output logic [6:0]             shot_index,
    output logic                   fallback,
    output logic                   game_over,
    ai_shot_sequencer_if.master    ai
);

    typedef enum logic [2:0] {
        IDLE,
        WR_BOARD,
        WR_SHIPS,
        WR_START,
        RD_RESULT,
        CHECK,
        PRESENT
    } state_t;

    state_t           state;
    logic [CELLS-1:0] fired;
    logic [CELLS-1:0] fired_nxt;
    logic [4:0]       alive;
    logic [4:0]       alive_nxt;
    logic [6:0]       ai_capt;
    logic             clear_pend;
    logic             pend_any;
    logic             do_clear;
    logic             accept;
    logic [6:0]       lowest_free;
    logic             ai_ok;
    logic             unused_ok;

    // Only the cell index is meaningful in the ai read word.
    assign unused_ok = ^ai.ai_data_out[63:7];

    assign res_ready = (state == IDLE);
    assign accept    = res_valid & res_ready;
    assign pend_any  = clear_pend | new_game;

    function automatic logic [63:0] board_word(input logic [CELLS-1:0] f, input logic [2:0] a);
        case (a)
            3'd1:    return {{(64-WORD_CELLS){1'b0}}, f[0*WORD_CELLS +: WORD_CELLS]};
            3'd2:    return {{(64-WORD_CELLS){1'b0}}, f[1*WORD_CELLS +: WORD_CELLS]};
            3'd3:    return {{(64-WORD_CELLS){1'b0}}, f[2*WORD_CELLS +: WORD_CELLS]};
            3'd4:    return {{(64-WORD_CELLS){1'b0}}, f[3*WORD_CELLS +: WORD_CELLS]};
            default: return '0;
        endcase
    endfunction

    // A deferred new_game only takes effect once the ai read has completed.
    always_comb begin
        do_clear = 1'b0;
        case (state)
            IDLE, PRESENT: do_clear = new_game;
            RD_RESULT:     do_clear = pend_any & ~ai.ai_wait_request;
            CHECK:         do_clear = pend_any;
            default:       do_clear = 1'b0;
        endcase
    end

    always_comb begin
        fired_nxt = fired;
        alive_nxt = alive;
        if (do_clear) begin
            fired_nxt = '0;
            alive_nxt = 5'b11111;
        end else if (accept) begin
            if (res_index < 7'(CELLS))
                fired_nxt[res_index] = 1'b1;
            if (res_sunk && (res_sunk_id <= 3'd4))
                alive_nxt[res_sunk_id] = 1'b0;
        end
    end

    // Lowest unfired cell, used whenever the ai answer is unusable.
    always_comb begin
        lowest_free = '0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (!fired[i])
                lowest_free = 7'(i);
        end
        ai_ok = (ai_capt < 7'(CELLS)) && !fired[ai_capt];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            fired          <= '0;
            alive          <= 5'b11111;
            game_over      <= 1'b0;
            clear_pend     <= 1'b0;
            ai_capt        <= '0;
            ai.ai_addr     <= '0;
            ai.ai_write_en <= 1'b0;
            ai.ai_read_en  <= 1'b0;
            ai.ai_data_in  <= '0;
            shot_valid     <= 1'b0;
            shot_index     <= '0;
            fallback       <= 1'b0;
        end else begin
            fired     <= fired_nxt;
            alive     <= alive_nxt;
            game_over <= (alive_nxt == 5'd0);

            if (new_game && (state inside {WR_BOARD, WR_SHIPS, WR_START, RD_RESULT}))
                clear_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (!new_game && !res_valid && shot_req && !game_over) begin
                        state          <= WR_BOARD;
                        ai.ai_addr     <= 3'd1;
                        ai.ai_write_en <= 1'b1;
                        ai.ai_data_in  <= board_word(fired, 3'd1);
                    end
                end

                WR_BOARD: begin
                    if (!ai.ai_wait_request) begin
                        if (ai.ai_addr == 3'd4) begin
                            state         <= WR_SHIPS;
                            ai.ai_addr    <= 3'd5;
                            ai.ai_data_in <= {59'b0, alive};
                        end else begin
                            ai.ai_addr    <= ai.ai_addr + 3'd1;
                            ai.ai_data_in <= board_word(fired, ai.ai_addr + 3'd1);
                        end
                    end
                end

                WR_SHIPS: begin
                    if (!ai.ai_wait_request) begin
                        state         <= WR_START;
                        ai.ai_addr    <= 3'd0;
                        ai.ai_data_in <= '0;
                    end
                end

                WR_START: begin
                    if (!ai.ai_wait_request) begin
                        state          <= RD_RESULT;
                        ai.ai_write_en <= 1'b0;
                        ai.ai_read_en  <= 1'b1;
                    end
                end

                RD_RESULT: begin
                    if (!ai.ai_wait_request) begin
                        ai.ai_read_en <= 1'b0;
                        ai_capt       <= ai.ai_data_out[6:0];
                        if (pend_any) begin
                            clear_pend <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    if (pend_any) begin
                        clear_pend <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        shot_valid <= 1'b1;
                        shot_index <= ai_ok ? ai_capt : lowest_free;
                        fallback   <= ~ai_ok;
                        state      <= PRESENT;
                    end
                end

                PRESENT: begin
                    if (new_game || shot_ready) begin
                        shot_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ai_shot_sequencer.sv
// tb/tb_ai_shot_sequencer.sv - randomized self-checking bench for ai_shot_sequencer with an ai slave model
module tb_ai_shot_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        new_game;
    logic        res_valid;
    logic        res_ready;
    logic [6:0]  res_index;
    logic        res_sunk;
    logic [2:0]  res_sunk_id;
    logic        shot_req;
    logic        shot_valid;
    logic        shot_ready;
    logic [6:0]  shot_index;
    logic        fallback;
    logic        game_over;

    ai_shot_sequencer_if ai_bus ();

    ai_shot_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .new_game    (new_game),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_index   (res_index),
        .res_sunk    (res_sunk),
        .res_sunk_id (res_sunk_id),
        .shot_req    (shot_req),
        .shot_valid  (shot_valid),
        .shot_ready  (shot_ready),
        .shot_index  (shot_index),
        .fallback    (fallback),
        .game_over   (game_over),
        .ai          (ai_bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference board: plain arrays updated from the result rules.
    bit       fired_m [100];
    bit [4:0] alive_m;

    function automatic logic [63:0] word_m(input int k);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 25; j++)
            if (fired_m[25*k + j]) w[j] = 1'b1;
        return w;
    endfunction

    function automatic int lowest_m();
        for (int i = 0; i < 100; i++)
            if (!fired_m[i]) return i;
        return 0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 100; i++) fired_m[i] = 1'b0;
        alive_m = 5'b11111;
    endtask

    // ai slave model: per-transfer stall counts, records completed transfers.
    typedef struct packed {
        logic        rd;
        logic [2:0]  addr;
        logic [63:0] data;
    } xfer_t;

    xfer_t       xq [$];
    xfer_t       xt;
    int          stall_wr [8];
    int          stall_rd;
    logic [6:0]  ai_ret;
    bit          busy;
    int          cnt;
    bit          prev_stall;
    logic [2:0]  p_addr;
    logic [63:0] p_data;
    logic [1:0]  p_en;
    logic [63:0] rdata;

    always @(negedge clock) begin
        if (prev_stall) begin
            chk("hold_addr", 64'(ai_bus.ai_addr), 64'(p_addr));
            chk("hold_data", ai_bus.ai_data_in, p_data);
            chk("hold_en", 64'({ai_bus.ai_write_en, ai_bus.ai_read_en}), 64'(p_en));
        end
        if (ai_bus.ai_write_en || ai_bus.ai_read_en) begin
            chk("one_enable", 64'(ai_bus.ai_write_en & ai_bus.ai_read_en), 64'd0);
            if (!busy) begin
                busy = 1'b1;
                cnt  = ai_bus.ai_read_en ? stall_rd : stall_wr[ai_bus.ai_addr];
            end
            rdata = {$urandom(), $urandom()};
            rdata[6:0] = ai_ret;
            ai_bus.ai_data_out = rdata;
            if (cnt > 0) begin
                ai_bus.ai_wait_request = 1'b1;
                cnt--;
            end else begin
                ai_bus.ai_wait_request = 1'b0;
                busy    = 1'b0;
                xt.rd   = ai_bus.ai_read_en;
                xt.addr = ai_bus.ai_addr;
                xt.data = ai_bus.ai_data_in;
                xq.push_back(xt);
            end
        end else begin
            ai_bus.ai_wait_request = 1'($urandom_range(0, 1));
            ai_bus.ai_data_out     = {$urandom(), $urandom()};
        end
        prev_stall = (ai_bus.ai_write_en || ai_bus.ai_read_en) && ai_bus.ai_wait_request;
        p_addr     = ai_bus.ai_addr;
        p_data     = ai_bus.ai_data_in;
        p_en       = {ai_bus.ai_write_en, ai_bus.ai_read_en};
    end

    task automatic set_stalls(input int maxw, input int maxr);
        for (int i = 0; i < 8; i++) stall_wr[i] = $urandom_range(0, maxw);
        stall_rd = $urandom_range(0, maxr);
    endtask

    task automatic send_result(input int idx, input bit sunk, input int id);
        @(negedge clock);
        res_valid   = 1'b1;
        res_index   = 7'(idx);
        res_sunk    = sunk;
        res_sunk_id = 3'(id);
        chk("res_ready_idle", 64'(res_ready), 64'd1);
        @(negedge clock);
        res_valid = 1'b0;
        res_sunk  = 1'b0;
        if (idx < 100) fired_m[idx] = 1'b1;
        if (sunk && id <= 4) alive_m[id] = 1'b0;
        chk("game_over", 64'(game_over), 64'(alive_m == 5'd0));
    endtask

    task automatic pulse_new_game();
        @(negedge clock);
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
        clear_model();
        chk("ng_game_over", 64'(game_over), 64'd0);
    endtask

    task automatic check_xfers();
        logic [63:0] ed;
        logic [2:0]  ea;
        chk("xfer_count", 64'(xq.size()), 64'd7);
        for (int i = 0; i < 7 && i < xq.size(); i++) begin
            ea = (i < 4) ? 3'(i + 1) : (i == 4) ? 3'd5 : 3'd0;
            ed = (i < 4) ? word_m(i) : (i == 4) ? 64'(alive_m) : 64'd0;
            chk($sformatf("xfer%0d_rd", i), 64'(xq[i].rd), 64'(i == 6));
            chk($sformatf("xfer%0d_addr", i), 64'(xq[i].addr), 64'(ea));
            if (i < 6) chk($sformatf("xfer%0d_data", i), xq[i].data, ed);
        end
    endtask

    task automatic do_shot(input logic [6:0] ret);
        int cycles;
        int exp_lat;
        int exp_idx;
        bit exp_fb;
        ai_ret  = ret;
        exp_lat = 9 + stall_rd;
        for (int i = 0; i < 6; i++) exp_lat += stall_wr[i];
        if (ret < 100 && !fired_m[ret]) begin
            exp_idx = ret;
            exp_fb  = 1'b0;
        end else begin
            exp_idx = lowest_m();
            exp_fb  = 1'b1;
        end
        xq.delete();
        @(negedge clock);
        shot_req = 1'b1;
        @(negedge clock);
        shot_req = 1'b0;
        cycles   = 1;
        while (!shot_valid && cycles < 300) begin
            @(negedge clock);
            cycles++;
        end
        chk("shot_latency", 64'(cycles), 64'(exp_lat));
        chk("shot_index", 64'(shot_index), 64'(exp_idx));
        chk("fallback", 64'(fallback), 64'(exp_fb));
        check_xfers();
        shot_ready = 1'b1;
        @(negedge clock);
        shot_ready = 1'b0;
        chk("shot_drop", 64'(shot_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        reset       = 1'b1;
        new_game    = 1'b0;
        res_valid   = 1'b0;
        res_index   = '0;
        res_sunk    = 1'b0;
        res_sunk_id = '0;
        shot_req    = 1'b0;
        shot_ready  = 1'b0;
        ai_ret      = '0;
        busy        = 1'b0;
        cnt         = 0;
        prev_stall  = 1'b0;
        for (int i = 0; i < 8; i++) stall_wr[i] = 0;
        stall_rd = 0;
        clear_model();
        repeat (3) @(negedge clock);
        chk("rst_addr", 64'(ai_bus.ai_addr), 64'd0);
        chk("rst_wen", 64'(ai_bus.ai_write_en), 64'd0);
        chk("rst_ren", 64'(ai_bus.ai_read_en), 64'd0);
        chk("rst_data", ai_bus.ai_data_in, 64'd0);
        chk("rst_valid", 64'(shot_valid), 64'd0);
        chk("rst_index", 64'(shot_index), 64'd0);
        chk("rst_fallback", 64'(fallback), 64'd0);
        chk("rst_game_over", 64'(game_over), 64'd0);
        chk("rst_res_ready", 64'(res_ready), 64'd1);
        reset = 1'b0;

        do_shot(7'd44);

        send_result(0, 1'b0, 0);
        send_result(24, 1'b0, 0);
        send_result(25, 1'b0, 0);
        send_result(99, 1'b0, 0);
        do_shot(7'd44);

        pulse_new_game();
        send_result(0, 1'b0, 0);
        send_result(1, 1'b0, 0);
        send_result(2, 1'b0, 0);
        do_shot(7'd0);
        do_shot(7'd127);

        stall_wr[3] = 5;
        stall_rd    = 20;
        do_shot(7'd60);
        set_stalls(0, 0);

        pulse_new_game();
        for (int id = 0; id < 5; id++) begin
            send_result(10 + id, 1'b1, id);
            if (id < 4) do_shot(7'($urandom_range(0, 127)));
        end
        chk("sunk_all_game_over", 64'(game_over), 64'd1);
        xq.delete();
        @(negedge clock);
        shot_req = 1'b1;
        repeat (20) @(negedge clock);
        shot_req = 1'b0;
        chk("go_no_traffic", 64'(xq.size()), 64'd0);
        chk("go_no_valid", 64'(shot_valid), 64'd0);

        pulse_new_game();
        send_result(30, 1'b0, 0);
        send_result(31, 1'b1, 1);
        stall_rd = 8;
        ai_ret   = 7'd7;
        xq.delete();
        @(negedge clock);
        shot_req = 1'b1;
        @(negedge clock);
        shot_req = 1'b0;
        n = 0;
        while (!ai_bus.ai_read_en && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("abort_reach_read", 64'(ai_bus.ai_read_en), 64'd1);
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (shot_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        chk("abort_read_done", 64'(xq.size()), 64'd7);
        chk("abort_idle", 64'(res_ready), 64'd1);
        clear_model();
        stall_rd = 0;
        do_shot(7'd7);

        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 3);
            for (int r = 0; r < n; r++)
                send_result($urandom_range(0, 127), ($urandom_range(0, 9) == 0), $urandom_range(0, 7));
            if (alive_m == 5'd0) pulse_new_game();
            set_stalls(2, 3);
            do_shot(7'($urandom_range(0, 127)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
